binary_to_bcd: RTL and testbench
================================

Name: binary_to_bcd

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Converts an unsigned binary word into three BCD digits: hundreds, tens and ones.
- Used in display and readout paths that need decimal digits from a binary count.
- Runs one algorithm iteration per clock, with a start/busy/done handshake and registered digit outputs.

Parameters:
- WIDTH, 8, bit width of the binary input. Legal range is 4..9, so the maximum value 511 fits in three digits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only when idle.
- binary  input  WIDTH  unsigned value to convert; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when the digit outputs become valid.
- hundreds  output  4  BCD hundreds digit (0..9, or 0..5 for WIDTH=9).
- tens  output  4  BCD tens digit (0..9).
- ones  output  4  BCD ones digit (0..9).

Behaviour:
- Reset:
  - rst_n low immediately forces state IDLE, busy=0, done=0 and hundreds=tens=ones=0.
  - The internal shift register and iteration counter are cleared.
  - Reset asserted mid-conversion abandons the conversion; no done pulse follows.
- States: IDLE and CONVERT.
- IDLE:
  - busy=0.
  - If start=1 at a rising edge (edge k): capture binary into the low WIDTH bits of a (12+WIDTH)-bit scratch register with the BCD field zeroed, load counter=WIDTH, go to CONVERT.
- CONVERT (edges k+1 .. k+WIDTH):
  - busy=1.
  - Each edge first examines each 4-bit BCD field of the scratch register (ones, tens, hundreds) and adds 3 to any field >= 5.
  - The whole register then shifts left by one bit. Both steps happen in a single cycle.
  - The counter decrements on each edge.
- Completion:
  - At edge k+WIDTH the final shifted BCD fields are written to hundreds/tens/ones, state returns to IDLE and done=1.
  - done=1 for exactly one cycle, the cycle after edge k+WIDTH. The latency from the accepted start edge to done high is WIDTH cycles.
- Output hold:
  - hundreds/tens/ones change only at completion or reset.
  - Between conversions they hold the last result, including while busy.
- start while busy is ignored (no queueing); binary changes while busy do not affect the result.
- start=1 in the cycle done is high is accepted: back-to-back conversions with no idle gap.
- start held high continuously gives continuous conversions, one every WIDTH+1 edges.
- Arithmetic:
  - The result is an exact decimal representation: hundreds*100 + tens*10 + ones == binary.
  - Every digit is always <= 9, and the add-3 correction never overflows a 4-bit field.
- Boundaries:
  - binary=0 gives 0,0,0.
  - binary=2^WIDTH-1 gives the correct maximum; for WIDTH=8 that is 255 -> 2,5,5.

Test Plan:
1. Reset: assert rst_n=0 mid-conversion of 200 -> outputs 0,0,0, busy=0, done=0 immediately. After release, no done pulse appears without a new start.
2. Single conversions (WIDTH=8), one start each, wait for done:
   - 10 -> 0,1,0
   - 51 -> 0,5,1
   - 100 -> 1,0,0
   - 150 -> 1,5,0
   - 200 -> 2,0,0
   - 249 -> 2,4,9
   - In every case done pulses exactly 8 cycles after the start edge, and busy is high for exactly 8 cycles.
3. Extremes: 0 -> 0,0,0; 255 -> 2,5,5; 99 -> 0,9,9 (correction on both lower digits).
4. Ignore while busy: start 150, then pulse start with binary=7 at cycle 3 -> result 1,5,0 with a single done pulse. Outputs hold 1,5,0 afterwards.
5. Back-to-back: start held high with binary toggling 51/249 at each accepted start -> alternating 0,5,1 and 2,4,9, with done every 9 cycles.
6. Exhaustive: all 256 inputs checked against an integer /100, /10, %10 reference model.

Source files
------------

// File: rtl/binary_to_bcd_if.sv
// binary_to_bcd_if: handshake and digit bus; master drives start/binary, slave drives busy/done/hundreds/tens/ones
interface binary_to_bcd_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] binary;
  logic busy;
  logic done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  modport master(output start, binary, input busy, done, hundreds, tens, ones);
  modport slave(input start, binary, output busy, done, hundreds, tens, ones);
endinterface

// File: rtl/binary_to_bcd.sv
// binary_to_bcd: sequential double-dabble converter; ports clk, rst_n (async low), bus.slave (start/binary in, busy/done/hundreds/tens/ones out)
module binary_to_bcd #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  binary_to_bcd_if.slave bus
);
  typedef enum logic {IDLE, CONVERT} state_t;
  state_t state;
  logic [11+WIDTH:0] sr;
  logic [11+WIDTH:0] fixed;
  logic [11+WIDTH:0] next_sr;
  logic [3:0] cnt;
  always_comb begin
    fixed = sr;
    for (int i = 0; i < 3; i++)
      fixed[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] >= 4'd5 ? sr[WIDTH+4*i +: 4] + 4'd3 : sr[WIDTH+4*i +: 4];
    next_sr = {fixed[10+WIDTH:0], 1'b0};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hundreds <= '0;
      bus.tens <= '0;
      bus.ones <= '0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          sr <= {12'd0, bus.binary};
          cnt <= 4'(WIDTH);
          state <= CONVERT;
          bus.busy <= 1'b1;
        end
      end else begin
        sr <= next_sr;
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.ones <= next_sr[WIDTH +: 4];
          bus.tens <= next_sr[WIDTH+4 +: 4];
          bus.hundreds <= next_sr[WIDTH+8 +: 4];
        end
      end
    end
endmodule

// File: tb/tb_binary_to_bcd.sv
// tb_binary_to_bcd: directed self-checking bench with an arithmetic reference model for binary_to_bcd
module tb_binary_to_bcd;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;
  binary_to_bcd_if #(.WIDTH(W)) bus();
  binary_to_bcd #(.WIDTH(W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  logic m_busy, m_done;
  int m_left, m_val;
  logic [3:0] m_h, m_t, m_o;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_val <= 0;
      m_h <= '0;
      m_t <= '0;
      m_o <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy && bus.start) begin
        m_busy <= 1'b1;
        m_left <= W;
        m_val <= int'(bus.binary);
      end else if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_h <= 4'(m_val / 100);
          m_t <= 4'((m_val / 10) % 10);
          m_o <= 4'(m_val % 10);
        end
      end
    end
  always @(negedge clk)
    if (check_en) begin
      checks++;
      if (bus.busy !== m_busy || bus.done !== m_done || bus.hundreds !== m_h || bus.tens !== m_t || bus.ones !== m_o) begin
        errors++;
        $display("FAIL model_cycle t=%0t got busy=%b done=%b %0d,%0d,%0d expected busy=%b done=%b %0d,%0d,%0d",
                 $time, bus.busy, bus.done, bus.hundreds, bus.tens, bus.ones, m_busy, m_done, m_h, m_t, m_o);
      end
    end
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic convert(input int val, input int eh, input int et, input int eo, input logic pin);
    int lat;
    int bc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.binary = W'(val);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    bc = int'(bus.busy);
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
      bc += int'(bus.busy);
    end
    if (pin) begin
      check("latency", lat, W);
      check("busy_cycles", bc, W);
      check("hundreds", int'(bus.hundreds), eh);
      check("tens", int'(bus.tens), et);
      check("ones", int'(bus.ones), eo);
    end else if (!bus.done) check("done_timeout", lat, W);
  endtask
  initial begin
    int dones;
    int gap;
    int vals[2];
    bus.start = 1'b0;
    bus.binary = '0;
    #1;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_digits", int'({bus.hundreds, bus.tens, bus.ones}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    convert(10, 0, 1, 0, 1'b1);
    convert(51, 0, 5, 1, 1'b1);
    convert(100, 1, 0, 0, 1'b1);
    convert(150, 1, 5, 0, 1'b1);
    convert(200, 2, 0, 0, 1'b1);
    convert(249, 2, 4, 9, 1'b1);
    convert(0, 0, 0, 0, 1'b1);
    convert(255, 2, 5, 5, 1'b1);
    convert(99, 0, 9, 9, 1'b1);
    // start ignored while busy
    @(negedge clk);
    bus.start = 1'b1;
    bus.binary = 8'd150;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.binary = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      dones += int'(bus.done);
    end
    check("ignore_dones", dones, 1);
    check("ignore_digits", int'({bus.hundreds, bus.tens, bus.ones}), 12'h150);
    // back-to-back with start held high
    vals[0] = 51;
    vals[1] = 249;
    @(negedge clk);
    bus.start = 1'b1;
    bus.binary = 8'd51;
    for (int n = 0; n < 4; n++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!bus.done && gap < 30);
      if (n > 0) check("b2b_gap", gap, W + 1);
      check("b2b_value", int'(bus.hundreds) * 100 + int'(bus.tens) * 10 + int'(bus.ones), vals[n % 2]);
      bus.binary = W'(vals[(n + 1) % 2]);
      if (n == 3) bus.start = 1'b0;
    end
    repeat (3) @(negedge clk);
    // reset mid-conversion of 200
    @(negedge clk);
    bus.start = 1'b1;
    bus.binary = 8'd200;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_done", int'(bus.done), 0);
    check("midreset_digits", int'({bus.hundreds, bus.tens, bus.ones}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      dones += int'(bus.done);
    end
    check("post_reset_dones", dones, 0);
    for (int v = 0; v < 256; v++) begin
      convert(v, 0, 0, 0, 1'b0);
      check("exhaustive", int'(bus.hundreds) * 100 + int'(bus.tens) * 10 + int'(bus.ones), v);
    end
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
